eff: RTL and testbench

Registered DES round function f(R, K) for a DES cipher datapath. It takes the 32-bit right half-block and the 48-bit round subkey and applies E-expansion, key XOR, S-box substitution S1–S8 and the P permutation, all per FIPS 46-3. The result is registered once. The round/key-schedule controller feeds it once per round, and the surrounding Feistel logic XORs the output into the left half.

---
 rtl/eff.sv | 66 ++++++
 tb/tb_eff.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/eff.sv
// rtl/eff.sv - registered DES round function f(R, K)
module eff (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] f_reg_in,
  input  logic [47:0] key,
  output logic [31:0] f_reg_out
);

  // S-box contents, 64 hex digits each: row 0 columns 0..15 first, row 3 column 15 last.
  localparam logic [255:0] S1_TBL = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] S2_TBL = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] S3_TBL = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] S4_TBL = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] S5_TBL = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] S6_TBL = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] S7_TBL = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  localparam logic [255:0] S8_TBL = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  // Row is the outer bit pair {b1,b6}, column the inner four bits b2..b5.
  function automatic logic [3:0] sbox(input logic [255:0] tbl, input logic [5:0] grp);
    logic [5:0] idx;
    logic [7:0] pos;
    idx = {grp[5], grp[0], grp[4:1]};
    pos = {~idx, 2'b00};
    return tbl[pos +: 4];
  endfunction

  // DES bit n sits at index 32-n, so the E table is a fixed concatenation.
  function automatic logic [47:0] expand(input logic [31:0] r);
    return {r[0], r[31:27], r[28:23], r[24:19], r[20:15],
            r[16:11], r[12:7], r[8:3], r[4:0], r[31]};
  endfunction

  // P table rewritten as source indices (32 - P[i]).
  function automatic logic [31:0] permute(input logic [31:0] s);
    return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
            s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
            s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
            s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
  endfunction

  logic [47:0] mixed;
  logic [31:0] subst;
  logic [31:0] f_next;

  // Expansion, key mixing, substitution and permutation all settle within one cycle.
  always_comb begin
    mixed  = expand(f_reg_in) ^ key;
    subst  = {sbox(S1_TBL, mixed[47:42]), sbox(S2_TBL, mixed[41:36]),
              sbox(S3_TBL, mixed[35:30]), sbox(S4_TBL, mixed[29:24]),
              sbox(S5_TBL, mixed[23:18]), sbox(S6_TBL, mixed[17:12]),
              sbox(S7_TBL, mixed[11:6]),  sbox(S8_TBL, mixed[5:0])};
    f_next = permute(subst);
  end

  // Single output register; reset clears it and discards that edge's result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_reg_out <= 32'h0000_0000;
    end else begin
      f_reg_out <= f_next;
    end
  end

endmodule

// File: tb/tb_eff.sv
// tb/tb_eff.sv - self-checking bench for eff against a table-driven DES f model
module tb_eff;

  logic        clk;
  logic        rst_n;
  logic [31:0] f_reg_in;
  logic [47:0] key;
  logic [31:0] f_reg_out;

  int n_cmp = 0;
  int n_bad = 0;

  eff dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_reg_in  (f_reg_in),
    .key       (key),
    .f_reg_out (f_reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int e_tab [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                     12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                     24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  int p_tab [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  int sb [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  bit hit [8][4][16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference f(R,K) working directly in DES bit numbers (bit n of a W-bit word = index W-n).
  task automatic model_f(input logic [31:0] r, input logic [47:0] k, output logic [31:0] res);
    logic [47:0] x;
    logic [31:0] s;
    int row, col, v;
    for (int i = 1; i <= 48; i++) x[48 - i] = r[32 - e_tab[i - 1]] ^ k[48 - i];
    for (int b = 0; b < 8; b++) begin
      row = 2 * x[48 - (6 * b + 1)] + x[48 - (6 * b + 6)];
      col = 8 * x[48 - (6 * b + 2)] + 4 * x[48 - (6 * b + 3)]
          + 2 * x[48 - (6 * b + 4)] + x[48 - (6 * b + 5)];
      hit[b][row][col] = 1'b1;
      v = sb[b][row][col];
      for (int j = 0; j < 4; j++) s[31 - 4 * b - j] = v[3 - j];
    end
    for (int i = 1; i <= 32; i++) res[32 - i] = s[32 - p_tab[i - 1]];
  endtask

  // Present inputs, let one rising edge pass, then settle away from the edge.
  task automatic step(input logic rst, input logic [31:0] r, input logic [47:0] k);
    rst_n    = rst;
    f_reg_in = r;
    key      = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r_v, exp_v;
    logic [47:0] k_v;
    int hits;

    rst_n = 1'b0; f_reg_in = '0; key = '0;
    @(negedge clk);

    step(1'b0, $urandom, {$urandom, $urandom} >> 16);
    chk("reset_edge1", f_reg_out, 32'h0000_0000);
    step(1'b0, $urandom, {$urandom, $urandom} >> 16);
    chk("reset_edge2", f_reg_out, 32'h0000_0000);

    step(1'b1, 32'h0, 48'h0);
    chk("zero_vec", f_reg_out, 32'hD8D8DBBC);

    step(1'b1, 32'h0000FFFF, 48'h0);
    chk("half_ones", f_reg_out, 32'hD81CF1DD);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h0000FFFF, 48'h0);
      chk("half_ones_hold", f_reg_out, 32'hD81CF1DD);
    end

    step(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072);
    chk("fips_round1", f_reg_out, 32'h234AA9BB);

    step(1'b1, 32'h0, 48'h0);
    chk("b2b_0", f_reg_out, 32'hD8D8DBBC);
    step(1'b1, 32'h0000FFFF, 48'h0);
    chk("b2b_1", f_reg_out, 32'hD81CF1DD);
    step(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072);
    chk("b2b_2", f_reg_out, 32'h234AA9BB);

    step(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072);
    chk("mid_pre", f_reg_out, 32'h234AA9BB);
    step(1'b0, 32'h0000FFFF, 48'h0);
    chk("mid_reset", f_reg_out, 32'h0000_0000);
    step(1'b1, 32'h0000FFFF, 48'h0);
    chk("mid_post", f_reg_out, 32'hD81CF1DD);

    for (int i = 0; i < 10000; i++) begin
      r_v = $urandom;
      k_v = {$urandom, $urandom} >> 16;
      model_f(r_v, k_v, exp_v);
      step(1'b1, r_v, k_v);
      chk("random", f_reg_out, exp_v);
    end

    hits = 0;
    for (int b = 0; b < 8; b++)
      for (int rw = 0; rw < 4; rw++)
        for (int c = 0; c < 16; c++)
          hits += hit[b][rw][c];
    n_cmp++;
    if (hits != 512) begin
      n_bad++;
      $display("FAIL sbox_coverage: got %0d entries hit expected 512", hits);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
